// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared encodings and defaults for the sprite motion engine.
//             Holds the vertical motion state encoding and the joystick
//             dead-zone thresholds used by the top level and by any other
//             block that decodes the PmodJSTK X axis.
//  Contents : mstate_e  - GROUND / RISE / FALL state encoding
//             JOY_LO_DEF, JOY_HI_DEF - dead-zone edges for a 10-bit axis
//             sat_add5  - saturating 5-bit velocity increment
//  Revision : 1.0  initial release
// ============================================================================
package sprite_pkg;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } mstate_e;

   localparam int JOY_LO_DEF = 400;
   localparam int JOY_HI_DEF = 600;

   // Adds inc to val and clamps the result at cap; the sum is formed in
   // 6 bits so a velocity near 31 cannot wrap before the clamp is applied.
   function automatic logic [4:0] sat_add5(input logic [4:0] val,
                                          input logic [4:0] inc,
                                          input logic [4:0] cap);
      logic [5:0] sum;
      sum = {1'b0, val} + {1'b0, inc};
      if (sum > {1'b0, cap}) begin
         return cap;
      end
      return sum[4:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tick_edge_detect
//  Purpose  : Rising-edge detector for a button level, sampled only on
//             accepted update strobes. The previous level is remembered
//             only when en_i is high, so an edge is seen relative to the
//             last accepted tick rather than the last clock.
//  Ports    : clk     in  system clock
//             rst_n   in  asynchronous active-low reset
//             en_i    in  accepted update strobe (tick and not frozen)
//             btn_i   in  button level
//             edge_o  out button high now, low at the previous accepted tick
//  Revision : 1.0  initial release
// ============================================================================
module tick_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic btn_i,
   output logic edge_o
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
      end else if (en_i) begin
         prev_q <= btn_i;
      end
   end

   // Combinational so the edge is usable on the same tick that samples it.
   assign edge_o = btn_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_motion_ctrl
//  Purpose  : Joystick-driven sprite motion engine. Moves the sprite
//             horizontally from the joystick X axis and runs a simple
//             gravity jump model (variable height, optional multi-jump)
//             with screen clamping. State advances only on accepted ticks.
//  Ports    : clk            in   system clock
//             rst_n          in   asynchronous active-low reset
//             tick_i         in   1-cycle update strobe
//             freeze_i       in   hold all state, ignore ticks
//             jstk_x_i       in   joystick X, 0..1023
//             jump_btn_i     in   jump button level
//             pos_x_o        out  sprite left edge
//             pos_y_o        out  sprite top edge
//             vel_y_o        out  vertical speed magnitude
//             mstate_o       out  0 GROUND, 1 RISE, 2 FALL
//             facing_left_o  out  last horizontal direction was left
//             jumps_used_o   out  jumps since the last landing
//  Revision : 1.0  initial release
// ============================================================================
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int POS_W      = 10,
   parameter int SCREEN_W   = 640,
   parameter int IMG_W      = 160,
   parameter int GROUND_Y   = 360,
   parameter int X_STEP     = 3,
   parameter int JUMP_V     = 8,
   parameter int GRAVITY    = 1,
   parameter int MAX_FALL_V = 8,
   parameter int JOY_LO     = JOY_LO_DEF,
   parameter int JOY_HI     = JOY_HI_DEF,
   parameter int MAX_JUMPS  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_i,
   input  logic             freeze_i,
   input  logic [9:0]       jstk_x_i,
   input  logic             jump_btn_i,
   output logic [POS_W-1:0] pos_x_o,
   output logic [POS_W-1:0] pos_y_o,
   output logic [4:0]       vel_y_o,
   output logic [1:0]       mstate_o,
   output logic             facing_left_o,
   output logic [1:0]       jumps_used_o
);

   // ------------------------------------------------------------------
   // Sized constants
   // ------------------------------------------------------------------
   localparam logic [9:0]           JOY_LO_V  = 10'(JOY_LO);
   localparam logic [9:0]           JOY_HI_V  = 10'(JOY_HI);
   localparam logic [POS_W-1:0]     X_MAX_V   = POS_W'(SCREEN_W - IMG_W);
   localparam logic [POS_W-1:0]     X_STEP_V  = POS_W'(X_STEP);
   localparam logic [POS_W-1:0]     GROUND_V  = POS_W'(GROUND_Y);
   localparam logic signed [POS_W:0] GROUND_S = (POS_W+1)'(GROUND_Y);
   localparam logic [4:0]           JUMP_V_V  = 5'(JUMP_V);
   localparam logic [4:0]           GRAV_V    = 5'(GRAVITY);
   localparam logic [4:0]           MAXF_V    = 5'(MAX_FALL_V);
   localparam logic [1:0]           MAXJ_V    = 2'(MAX_JUMPS);

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   logic [POS_W-1:0] x_q, x_d;
   logic             facing_q, facing_d;
   logic [POS_W-1:0] y_q;
   logic [4:0]       vel_q;
   mstate_e          st_q;
   logic [1:0]       jumps_q;

   logic accept;
   logic jump_edge;

   assign accept = tick_i & ~freeze_i;

   tick_edge_detect u_jump_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (accept),
      .btn_i  (jump_btn_i),
      .edge_o (jump_edge)
   );

   // ------------------------------------------------------------------
   // Horizontal datapath. Clamp tests compare distances to the limit so
   // the step never wraps the POS_W-bit position.
   // ------------------------------------------------------------------
   always_comb begin
      x_d      = x_q;
      facing_d = facing_q;
      if (jstk_x_i < JOY_LO_V) begin
         facing_d = 1'b1;
         if (x_q > X_STEP_V) begin
            x_d = x_q - X_STEP_V;
         end else begin
            x_d = '0;
         end
      end else if (jstk_x_i > JOY_HI_V) begin
         facing_d = 1'b0;
         if ((X_MAX_V - x_q) > X_STEP_V) begin
            x_d = x_q + X_STEP_V;
         end else begin
            x_d = X_MAX_V;
         end
      end
   end

   // ------------------------------------------------------------------
   // Vertical candidates, one extra sign bit to expose underflow at the
   // top of the screen and overshoot past the ground line.
   // ------------------------------------------------------------------
   logic signed [POS_W:0] y_s;
   logic signed [POS_W:0] y_up;
   logic signed [POS_W:0] y_dn;
   logic [4:0]            vel_rise;
   logic [4:0]            vel_fall;
   logic                  air_ok;

   always_comb begin
      y_s      = $signed({1'b0, y_q});
      y_up     = y_s - $signed({{(POS_W-4){1'b0}}, vel_q});
      vel_fall = sat_add5(vel_q, GRAV_V, MAXF_V);
      y_dn     = y_s + $signed({{(POS_W-4){1'b0}}, vel_fall});
      vel_rise = (vel_q > GRAV_V) ? (vel_q - GRAV_V) : 5'd0;
      air_ok   = jump_edge && (jumps_q < MAXJ_V);
   end

   // ------------------------------------------------------------------
   // Motion state machine and all registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= '0;
         facing_q <= 1'b0;
         y_q      <= GROUND_V;
         vel_q    <= 5'd0;
         st_q     <= ST_GROUND;
         jumps_q  <= 2'd0;
      end else if (accept) begin
         x_q      <= x_d;
         facing_q <= facing_d;
         case (st_q)
            ST_GROUND: begin
               if (jump_edge) begin
                  st_q    <= ST_RISE;
                  vel_q   <= JUMP_V_V;
                  jumps_q <= 2'd1;
               end
            end
            ST_RISE: begin
               if (air_ok) begin
                  // A fresh jump restarts the rise; y is left for this tick.
                  vel_q   <= JUMP_V_V;
                  jumps_q <= jumps_q + 2'd1;
               end else if (!jump_btn_i) begin
                  // Early release cuts the jump short at the current height.
                  st_q  <= ST_FALL;
                  vel_q <= 5'd0;
               end else if (y_up[POS_W]) begin
                  y_q   <= '0;
                  vel_q <= 5'd0;
                  st_q  <= ST_FALL;
               end else begin
                  y_q   <= y_up[POS_W-1:0];
                  vel_q <= vel_rise;
                  if (vel_rise == 5'd0) begin
                     st_q <= ST_FALL;
                  end
               end
            end
            ST_FALL: begin
               // Landing is checked first so a jump edge on the landing
               // tick is dropped rather than launching from mid-air.
               if (y_dn >= GROUND_S) begin
                  y_q     <= GROUND_V;
                  vel_q   <= 5'd0;
                  jumps_q <= 2'd0;
                  st_q    <= ST_GROUND;
               end else if (air_ok) begin
                  st_q    <= ST_RISE;
                  vel_q   <= JUMP_V_V;
                  jumps_q <= jumps_q + 2'd1;
               end else begin
                  y_q   <= y_dn[POS_W-1:0];
                  vel_q <= vel_fall;
               end
            end
            default: begin
               st_q  <= ST_FALL;
               vel_q <= 5'd0;
            end
         endcase
      end
   end

   assign pos_x_o       = x_q;
   assign pos_y_o       = y_q;
   assign vel_y_o       = vel_q;
   assign mstate_o      = st_q;
   assign facing_left_o = facing_q;
   assign jumps_used_o  = jumps_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_motion_ctrl
//  Purpose  : Self-checking bench for sprite_motion_ctrl. Two instances run
//             side by side (single jump and double jump) against a
//             behavioural reference model of the motion rules, with
//             directed trajectories followed by randomized stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       freeze = 1'b0;
   logic [9:0] jx = 10'd500;
   logic       btn = 1'b0;

   logic [9:0] a_px, a_py, b_px, b_py;
   logic [4:0] a_vel, b_vel;
   logic [1:0] a_st, b_st, a_jmp, b_jmp;
   logic       a_fl, b_fl;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state, index 0 = single jump, 1 = double jump
   int m_x[2], m_y[2], m_v[2], m_s[2], m_f[2], m_j[2], m_b[2];
   int m_mj[2] = '{1, 2};

   always #5 clk = ~clk;

   sprite_motion_ctrl #(.MAX_JUMPS(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .tick_i(tick), .freeze_i(freeze),
      .jstk_x_i(jx), .jump_btn_i(btn),
      .pos_x_o(a_px), .pos_y_o(a_py), .vel_y_o(a_vel), .mstate_o(a_st),
      .facing_left_o(a_fl), .jumps_used_o(a_jmp)
   );

   sprite_motion_ctrl #(.MAX_JUMPS(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .tick_i(tick), .freeze_i(freeze),
      .jstk_x_i(jx), .jump_btn_i(btn),
      .pos_x_o(b_px), .pos_y_o(b_py), .vel_y_o(b_vel), .mstate_o(b_st),
      .facing_left_o(b_fl), .jumps_used_o(b_jmp)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_x[k] = 0; m_y[k] = 360; m_v[k] = 0; m_s[k] = 0;
         m_f[k] = 0; m_j[k] = 0; m_b[k] = 0;
      end
   endtask

   // One accepted tick of the motion rules, plain integer arithmetic.
   task automatic model_step(input int k);
      bit edge_seen;
      int nv, ny;
      edge_seen = (btn == 1'b1) && (m_b[k] == 0);
      m_b[k] = int'(btn);
      if (jx < 400) begin
         m_x[k] = (m_x[k] - 3 < 0) ? 0 : m_x[k] - 3;
         m_f[k] = 1;
      end else if (jx > 600) begin
         m_x[k] = (m_x[k] + 3 > 480) ? 480 : m_x[k] + 3;
         m_f[k] = 0;
      end
      if (m_s[k] == 0) begin
         if (edge_seen) begin
            m_s[k] = 1; m_v[k] = 8; m_j[k] = 1;
         end
      end else if (m_s[k] == 1) begin
         if (edge_seen && m_j[k] < m_mj[k]) begin
            m_v[k] = 8; m_j[k]++;
         end else if (!btn) begin
            m_s[k] = 2; m_v[k] = 0;
         end else if (m_y[k] - m_v[k] < 0) begin
            m_y[k] = 0; m_v[k] = 0; m_s[k] = 2;
         end else begin
            m_y[k] -= m_v[k];
            m_v[k] -= 1;
            if (m_v[k] == 0) m_s[k] = 2;
         end
      end else begin
         nv = (m_v[k] + 1 > 8) ? 8 : m_v[k] + 1;
         ny = m_y[k] + nv;
         if (ny >= 360) begin
            m_y[k] = 360; m_v[k] = 0; m_j[k] = 0; m_s[k] = 0;
         end else if (edge_seen && m_j[k] < m_mj[k]) begin
            m_s[k] = 1; m_v[k] = 8; m_j[k]++;
         end else begin
            m_y[k] = ny; m_v[k] = nv;
         end
      end
   endtask

   task automatic check_all();
      check_val("A.pos_x",  int'(a_px),  m_x[0]);
      check_val("A.pos_y",  int'(a_py),  m_y[0]);
      check_val("A.vel_y",  int'(a_vel), m_v[0]);
      check_val("A.mstate", int'(a_st),  m_s[0]);
      check_val("A.facing", int'(a_fl),  m_f[0]);
      check_val("A.jumps",  int'(a_jmp), m_j[0]);
      check_val("B.pos_x",  int'(b_px),  m_x[1]);
      check_val("B.pos_y",  int'(b_py),  m_y[1]);
      check_val("B.vel_y",  int'(b_vel), m_v[1]);
      check_val("B.mstate", int'(b_st),  m_s[1]);
      check_val("B.facing", int'(b_fl),  m_f[1]);
      check_val("B.jumps",  int'(b_jmp), m_j[1]);
   endtask

   // Drive one clock of stimulus (called just after a negedge), advance the
   // model at the active edge, then compare on the following negedge.
   task automatic cycle(input logic t, input logic f, input logic [9:0] x,
                        input logic b);
      tick = t; freeze = f; jx = x; btn = b;
      @(posedge clk);
      if (rst_n && t && !f) begin
         model_step(0);
         model_step(1);
      end
      @(negedge clk);
      check_all();
   endtask

   // Asserts reset away from the clock edge and checks the async response.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      cycle(1'b1, 1'b0, 10'd700, 1'b1);
      cycle(1'b1, 1'b0, 10'd100, 1'b1);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 10'd500, 1'b0);
   endtask

   int exp_y[17] = '{360, 352, 345, 339, 334, 330, 327, 325, 324,
                     325, 327, 330, 334, 339, 345, 352, 360};

   initial begin
      int hold;
      logic [9:0] rx;
      logic rb;
      model_reset();
      @(negedge clk);
      do_reset();

      // Full jump with the button held throughout
      for (int i = 0; i < 17; i++) begin
         cycle(1'b1, 1'b0, 10'd500, 1'b1);
         check_val("traj.pos_y", int'(a_py), exp_y[i]);
      end
      check_val("traj.landed", int'(a_st), 0);
      cycle(1'b1, 1'b0, 10'd500, 1'b0);

      // Horizontal travel and clamping
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 10'd700, 1'b0);
      check_val("x.after10", int'(a_px), 30);
      for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0, 10'd700, 1'b0);
      check_val("x.clamp_hi", int'(a_px), 480);
      for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0, 10'd100, 1'b0);
      check_val("x.clamp_lo", int'(a_px), 0);
      check_val("x.facing_l", int'(a_fl), 1);

      // Early release gives a short hop
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 10'd500, 1'b1);
      check_val("rel.y_before", int'(a_py), 345);
      cycle(1'b1, 1'b0, 10'd500, 1'b0);
      check_val("rel.state", int'(a_st), 2);
      check_val("rel.vel", int'(a_vel), 0);
      check_val("rel.y_hold", int'(a_py), 345);
      cycle(1'b1, 1'b0, 10'd500, 1'b0);
      check_val("rel.y_next", int'(a_py), 346);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 10'd500, 1'b0);

      // Double jump at the apex; only the MAX_JUMPS=2 instance accepts it
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 10'd500, 1'b1);
      check_val("dj.apex", int'(b_py), 324);
      cycle(1'b1, 1'b0, 10'd500, 1'b0);
      cycle(1'b1, 1'b0, 10'd500, 1'b1);
      check_val("dj.B.state", int'(b_st), 1);
      check_val("dj.B.vel", int'(b_vel), 8);
      check_val("dj.B.jumps", int'(b_jmp), 2);
      check_val("dj.A.state", int'(a_st), 2);
      cycle(1'b1, 1'b0, 10'd500, 1'b0);
      cycle(1'b1, 1'b0, 10'd500, 1'b1);
      check_val("dj.B.third", int'(b_jmp), 2);

      // Freeze during a rise holds everything
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 10'd500, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 10'd500, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 10'd700, 1'b0);
      check_val("frz.y", int'(a_py), 345);
      check_val("frz.x", int'(a_px), 0);

      // Randomized stimulus with a reset pulse in the middle
      hold = 0; rx = 10'd500; rb = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            rx = 10'($urandom_range(0, 1023));
            hold = $urandom_range(3, 30);
         end
         hold--;
         if ($urandom_range(0, 4) == 0) rb = ~rb;
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), rx, rb);
         if (i == 2000) begin
            while (m_s[0] != 2) cycle(1'b1, 1'b0, 10'd500, 1'b1);
            do_reset();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the bench always terminates
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
